// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file's single write port: per-source FIFOs for ALU and load
// results, a one-entry BL link slot, and a registered we3/wa3/wd3 output. Optional: REGFILE_WB_RR_FAIR_EN.
module regfile_wb_sched #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          m_valid,
   output logic          m_ready,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_data,
   input  logic          link_req,
   output logic          link_ready,
   input  logic [DW-1:0] link_pc,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   input  logic [AW-1:0] q_addr1,
   input  logic [AW-1:0] q_addr2,
   output logic          q_hit1,
   output logic          q_hit2
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;
   localparam logic [AW-1:0] LINK_REG = AW'(14);
   localparam logic [AW-1:0] PC_REG   = AW'(15);

   logic [AW-1:0] r_a_addr [DEPTH];
   logic [DW-1:0] r_a_data [DEPTH];
   logic [AW-1:0] r_m_addr [DEPTH];
   logic [DW-1:0] r_m_data [DEPTH];
   logic [PW-1:0] r_a_wp, r_a_rp, r_m_wp, r_m_rp;
   logic          r_link_full;
   logic [DW-1:0] r_link_pc;
`ifdef REGFILE_WB_RR_FAIR_EN
   logic          r_rr;
`endif

   logic          w_a_empty, w_a_full, w_m_empty, w_m_full;
   logic          w_a_push, w_m_push, w_link_push;
   logic          w_gnt_l, w_gnt_m, w_gnt_a, w_gnt_any;
   logic [AW-1:0] w_g_addr;
   logic [DW-1:0] w_g_data;
   logic [PW-1:0] w_a_cnt, w_m_cnt;
   logic          w_hit1, w_hit2;

   assign w_a_empty   = (r_a_wp == r_a_rp);
   assign w_m_empty   = (r_m_wp == r_m_rp);
   assign w_a_full    = (r_a_wp[PW-1] != r_a_rp[PW-1]) && (r_a_wp[IW-1:0] == r_a_rp[IW-1:0]);
   assign w_m_full    = (r_m_wp[PW-1] != r_m_rp[PW-1]) && (r_m_wp[IW-1:0] == r_m_rp[IW-1:0]);
   assign w_a_push    = a_valid && !w_a_full;
   assign w_m_push    = m_valid && !w_m_full;
   assign w_link_push = link_req && !r_link_full;
   assign w_a_cnt     = r_a_wp - r_a_rp;
   assign w_m_cnt     = r_m_wp - r_m_rp;

   assign a_ready    = !w_a_full;
   assign m_ready    = !w_m_full;
   assign link_ready = !r_link_full;

   // One grant per cycle: link always wins, then load/ALU by fixed or round-robin priority.
   always_comb begin
      w_gnt_l  = r_link_full;
      w_gnt_m  = 1'b0;
      w_gnt_a  = 1'b0;
      w_g_addr = LINK_REG;
      w_g_data = r_link_pc - DW'(4);
      if (!r_link_full) begin
`ifdef REGFILE_WB_RR_FAIR_EN
         if (!w_m_empty && (!r_rr || w_a_empty)) w_gnt_m = 1'b1;
         else if (!w_a_empty)                    w_gnt_a = 1'b1;
`else
         if (!w_m_empty)      w_gnt_m = 1'b1;
         else if (!w_a_empty) w_gnt_a = 1'b1;
`endif
      end
      if (w_gnt_m) begin
         w_g_addr = r_m_addr[r_m_rp[IW-1:0]];
         w_g_data = r_m_data[r_m_rp[IW-1:0]];
      end else if (w_gnt_a) begin
         w_g_addr = r_a_addr[r_a_rp[IW-1:0]];
         w_g_data = r_a_data[r_a_rp[IW-1:0]];
      end
   end
   assign w_gnt_any = w_gnt_l || w_gnt_m || w_gnt_a;

   // FIFO storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_a_push) begin
         r_a_addr[r_a_wp[IW-1:0]] <= a_addr;
         r_a_data[r_a_wp[IW-1:0]] <= a_data;
      end
      if (w_m_push) begin
         r_m_addr[r_m_wp[IW-1:0]] <= m_addr;
         r_m_data[r_m_wp[IW-1:0]] <= m_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_a_wp      <= '0;
         r_a_rp      <= '0;
         r_m_wp      <= '0;
         r_m_rp      <= '0;
         r_link_full <= 1'b0;
         r_link_pc   <= '0;
         we3         <= 1'b0;
         wa3         <= '0;
         wd3         <= '0;
`ifdef REGFILE_WB_RR_FAIR_EN
         r_rr        <= 1'b0;
`endif
      end else begin
         if (w_a_push) r_a_wp <= r_a_wp + PW'(1);
         if (w_m_push) r_m_wp <= r_m_wp + PW'(1);
         if (w_gnt_a)  r_a_rp <= r_a_rp + PW'(1);
         if (w_gnt_m)  r_m_rp <= r_m_rp + PW'(1);
         if (w_link_push) begin
            r_link_full <= 1'b1;
            r_link_pc   <= link_pc;
         end else if (w_gnt_l) begin
            r_link_full <= 1'b0;
         end
         // Writes to R15 are popped but never reach the register file.
         we3 <= w_gnt_any && (w_g_addr != PC_REG);
         if (w_gnt_any && (w_g_addr != PC_REG)) begin
            wa3 <= w_g_addr;
            wd3 <= w_g_data;
         end
`ifdef REGFILE_WB_RR_FAIR_EN
         if (w_gnt_m)      r_rr <= 1'b1;
         else if (w_gnt_a) r_rr <= 1'b0;
`endif
      end
   end

   // Pending-write hazard: any live FIFO entry, the link slot, or the write in flight.
   always_comb begin
      w_hit1 = (r_link_full && (q_addr1 == LINK_REG)) || (we3 && (wa3 == q_addr1));
      w_hit2 = (r_link_full && (q_addr2 == LINK_REG)) || (we3 && (wa3 == q_addr2));
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (PW'(k) < w_a_cnt) begin
            if (r_a_addr[IW'(r_a_rp[IW-1:0] + IW'(k))] == q_addr1) w_hit1 = 1'b1;
            if (r_a_addr[IW'(r_a_rp[IW-1:0] + IW'(k))] == q_addr2) w_hit2 = 1'b1;
         end
         if (PW'(k) < w_m_cnt) begin
            if (r_m_addr[IW'(r_m_rp[IW-1:0] + IW'(k))] == q_addr1) w_hit1 = 1'b1;
            if (r_m_addr[IW'(r_m_rp[IW-1:0] + IW'(k))] == q_addr2) w_hit2 = 1'b1;
         end
      end
   end
   assign q_hit1 = w_hit1 && (q_addr1 != PC_REG);
   assign q_hit2 = w_hit2 && (q_addr2 != PC_REG);

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic. Honours REGFILE_WB_RR_FAIR_EN.
module tb_regfile_wb_sched;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          a_valid, m_valid, link_req;
   logic          a_ready, m_ready, link_ready;
   logic [AW-1:0] a_addr, m_addr, q_addr1, q_addr2, wa3;
   logic [DW-1:0] a_data, m_data, link_pc, wd3;
   logic          we3, q_hit1, q_hit2;

   always #5 clk = ~clk;

   regfile_wb_sched #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
      .link_req(link_req), .link_ready(link_ready), .link_pc(link_pc),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: queues of {addr,data}, link slot, favoured-source bit, expected outputs.
   logic [AW+DW-1:0] ma_q[$];
   logic [AW+DW-1:0] mm_q[$];
   bit               ml_full;
   logic [DW-1:0]    ml_pc;
   bit               mod_rr;
   bit               e_we;
   logic [AW-1:0]    e_wa;
   logic [DW-1:0]    e_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hit(input logic [AW-1:0] a);
      if (a == 4'd15) return 1'b0;
      foreach (ma_q[i]) if (ma_q[i][AW+DW-1:DW] == a) return 1'b1;
      foreach (mm_q[i]) if (mm_q[i][AW+DW-1:DW] == a) return 1'b1;
      if (ml_full && a == 4'd14) return 1'b1;
      if (e_we && e_wa == a) return 1'b1;
      return 1'b0;
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      int               a_sz, m_sz;
      bit               lfull0, use_m, got;
      logic [AW+DW-1:0] ent;
      if (!reset_n) begin
         ma_q.delete(); mm_q.delete();
         ml_full = 0; ml_pc = '0; mod_rr = 0;
         e_we = 0; e_wa = '0; e_wd = '0;
         return;
      end
      a_sz = ma_q.size(); m_sz = mm_q.size(); lfull0 = ml_full;
      got = 0; ent = '0;
      if (lfull0) begin
         e_we = 1; e_wa = 4'd14; e_wd = ml_pc - 32'h4;
         ml_full = 0;
      end else begin
`ifdef REGFILE_WB_RR_FAIR_EN
         use_m = (m_sz > 0) && (!mod_rr || a_sz == 0);
`else
         use_m = (m_sz > 0);
`endif
         if (use_m) begin
            ent = mm_q.pop_front(); got = 1; mod_rr = 1;
         end else if (a_sz > 0) begin
            ent = ma_q.pop_front(); got = 1; mod_rr = 0;
         end
         if (got && ent[AW+DW-1:DW] != 4'd15) begin
            e_we = 1; e_wa = ent[AW+DW-1:DW]; e_wd = ent[DW-1:0];
         end else begin
            e_we = 0;
         end
      end
      if (a_valid && a_sz < DEPTH) ma_q.push_back({a_addr, a_data});
      if (m_valid && m_sz < DEPTH) mm_q.push_back({m_addr, m_data});
      if (link_req && !lfull0) begin
         ml_full = 1; ml_pc = link_pc;
      end
   endtask

   // Inputs are driven at the falling edge; one call covers one full clock.
   task automatic tick();
      #1;
      chk("q_hit1", q_hit1, m_hit(q_addr1));
      chk("q_hit2", q_hit2, m_hit(q_addr2));
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("we3", we3, e_we);
      chk("wa3", wa3, e_wa);
      chk("wd3", wd3, e_wd);
      chk("a_ready", a_ready, ma_q.size() < DEPTH);
      chk("m_ready", m_ready, mm_q.size() < DEPTH);
      chk("link_ready", link_ready, !ml_full);
   endtask

   task automatic idle_inputs();
      a_valid = 0; m_valid = 0; link_req = 0;
      a_addr = '0; m_addr = '0; a_data = '0; m_data = '0; link_pc = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 0;
      tick(); tick();
      reset_n = 1;
   endtask

   initial begin
      idle_inputs();
      reset_n = 0; q_addr1 = '0; q_addr2 = '0;
      @(negedge clk);

      // Reset held with a pending ALU request.
      a_valid = 1; a_addr = 4'd3; a_data = 32'h55; q_addr1 = 4'd3;
      tick(); tick();
      chk("rst_we3", we3, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_q_hit1", q_hit1, 0);
      idle_inputs(); reset_n = 1;

      // Single ALU write, two-cycle latency.
      a_valid = 1; a_addr = 4'd3; a_data = 32'h1234; q_addr1 = 4'd3;
      tick();
      a_valid = 0;
      chk("single_c1_we3", we3, 0);
      chk("single_c1_hit", q_hit1, 1);
      tick();
      chk("single_c2_we3", we3, 1);
      chk("single_c2_wa3", wa3, 3);
      chk("single_c2_wd3", wd3, 32'h1234);
      chk("single_c2_hit", q_hit1, 1);
      tick();
      chk("single_c3_we3", we3, 0);
      chk("single_c3_hit", q_hit1, 0);

      // Contention: link first, then load, then ALU.
      do_reset();
      a_valid = 1; a_addr = 4'd1; a_data = 32'hA;
      m_valid = 1; m_addr = 4'd2; m_data = 32'hB;
      link_req = 1; link_pc = 32'h108;
      tick();
      idle_inputs();
      chk("cont_c1_we3", we3, 0);
      tick();
      chk("cont_link_wa3", wa3, 14);
      chk("cont_link_wd3", wd3, 32'h104);
      tick();
      chk("cont_load_wa3", wa3, 2);
      chk("cont_load_wd3", wd3, 32'hB);
      tick();
      chk("cont_alu_wa3", wa3, 1);
      chk("cont_alu_wd3", wd3, 32'hA);
      tick();
      chk("cont_end_we3", we3, 0);

`ifndef REGFILE_WB_RR_FAIR_EN
      // ALU FIFO fills behind load traffic; the R15 entry is dropped.
      do_reset();
      a_valid = 1; a_addr = 4'd15; a_data = 32'hF;
      m_valid = 1; m_addr = 4'd7;  m_data = 32'h77;
      tick();
      a_addr = 4'd5; a_data = 32'h55;
      tick();
      chk("full_c2_a_ready", a_ready, 0);
      a_addr = 4'd6; a_data = 32'h66; m_valid = 0;
      tick();
      chk("full_c3_a_ready", a_ready, 0);
      tick();
      chk("full_r15_we3", we3, 0);
      chk("full_c4_a_ready", a_ready, 1);
      tick();
      a_valid = 0;
      chk("full_c5_we3", we3, 1);
      chk("full_c5_wa3", wa3, 5);
      chk("full_c5_wd3", wd3, 32'h55);
      tick();
      chk("full_c6_wa3", wa3, 6);
      chk("full_c6_wd3", wd3, 32'h66);
`else
      // Both sources saturated: grants alternate load, ALU, load, ALU.
      do_reset();
      a_valid = 1; a_addr = 4'd1; a_data = 32'hA1;
      m_valid = 1; m_addr = 4'd2; m_data = 32'hB2;
      tick(); tick();
      for (int k = 0; k < 6; k++) begin
         chk("rr_we3", we3, 1);
         chk("rr_wa3", wa3, (k % 2 == 0) ? 32'd2 : 32'd1);
         tick();
      end
      idle_inputs();
`endif

      // Reset with both FIFOs occupied discards everything.
      do_reset();
      a_valid = 1; a_addr = 4'd4; a_data = 32'h44;
      m_valid = 1; m_addr = 4'd8; m_data = 32'h88;
      tick(); tick(); tick();
      reset_n = 0;
      tick();
      reset_n = 1; idle_inputs();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("midrst_we3", we3, 0);
      end
      for (int q = 0; q < 16; q++) begin
         q_addr1 = 4'(q); q_addr2 = 4'(15 - q);
         tick();
         chk("midrst_hit1", q_hit1, 0);
         chk("midrst_hit2", q_hit2, 0);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         reset_n  = ($urandom_range(0, 249) != 0);
         a_valid  = ($urandom_range(0, 3) != 0);
         m_valid  = ($urandom_range(0, 2) != 0);
         a_addr   = 4'($urandom_range(0, 15));
         m_addr   = 4'($urandom_range(0, 15));
         a_data   = $urandom;
         m_data   = $urandom;
         link_req = !ml_full && ($urandom_range(0, 7) == 0);
         link_pc  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         q_addr1  = 4'($urandom_range(0, 15));
         q_addr2  = 4'($urandom_range(0, 15));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
